// File: rtl/aes_key_expand.sv
// Word-serial AES-128/192/256 key schedule producing Nr+1 round keys on a
// valid/ready stream; SubWord is performed by an external combinational S-box.
module aes_key_expand #(
    parameter int MAX_NK = 8,
    parameter int KEY_W  = 32 * MAX_NK
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             flush,
    input  logic             start,
    input  logic [1:0]       key_len,
    input  logic [KEY_W-1:0] key_i,
    output logic             ready,
    output logic             err,
    output logic [31:0]      sub_o,
    input  logic [31:0]      sub_i,
    output logic             rk_valid,
    input  logic             rk_ready,
    output logic [127:0]     rk_data,
    output logic [3:0]       rk_idx,
    output logic             rk_last
);
    localparam int IW = (MAX_NK > 1) ? $clog2(MAX_NK) : 1;

    typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [1:0]    klen;
    logic [31:0]   win [MAX_NK];
    logic [31:0]   rk_buf [3];
    logic [5:0]    idx;
    logic [3:0]    modc;
    logic [7:0]    rcon;

    logic [3:0]    nk, nr, in_nk;
    logic [IW-1:0] nk_m1;
    logic [5:0]    nw_last;
    logic          legal, accept, stall, advance, rk_load, rk_pop, expand_phase;
    logic [31:0]   prev_w, temp, new_w;

    always_comb begin
        case (klen)
            2'b00:   begin nk = 4'd4; nr = 4'd10; end
            2'b01:   begin nk = 4'd6; nr = 4'd12; end
            default: begin nk = 4'd8; nr = 4'd14; end
        endcase
        nk_m1   = IW'(nk - 4'd1);
        nw_last = {nr, 2'b11};
    end

    always_comb begin
        case (key_len)
            2'b00:   in_nk = 4'd4;
            2'b01:   in_nk = 4'd6;
            default: in_nk = 4'd8;
        endcase
        legal = (key_len != 2'b11) && (32'(in_nk) <= 32'(MAX_NK));
    end

    assign ready        = (state == IDLE);
    assign accept       = (state == IDLE) && start && legal;
    assign expand_phase = ({2'b00, nk} <= idx);
    assign stall        = (idx[1:0] == 2'b11) && rk_valid && !rk_ready;
    assign advance      = (state == GEN) && !stall;
    assign rk_load      = advance && (idx[1:0] == 2'b11);
    assign rk_pop       = rk_valid && rk_ready;

    // Window is a shift register: win[0] = w[i-Nk], win[Nk-1] = w[i-1].
    // During i<Nk it simply rotates, so the key words come out of win[0] in order.
    always_comb begin
        prev_w = win[nk_m1];
        temp   = prev_w;
        sub_o  = '0;
        new_w  = win[0];
        if (state == GEN && expand_phase) begin
            if (modc == 4'd0) begin
                sub_o = {prev_w[23:0], prev_w[31:24]};
                temp  = sub_i ^ {rcon, 24'h0};
            end else if (nk == 4'd8 && modc == 4'd4) begin
                sub_o = prev_w;
                temp  = sub_i;
            end
            new_w = win[0] ^ temp;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && legal) state_nxt = GEN;
                GEN:     if (advance && idx == nw_last) state_nxt = DRAIN;
                DRAIN:   if (rk_pop && rk_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            klen     <= '0;
            idx      <= '0;
            modc     <= '0;
            rcon     <= 8'h01;
            err      <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_idx   <= '0;
            rk_last  <= 1'b0;
            for (int unsigned j = 0; j < MAX_NK; j++) win[j] <= '0;
            for (int unsigned j = 0; j < 3; j++) rk_buf[j] <= '0;
        end else if (flush) begin
            klen     <= '0;
            idx      <= '0;
            modc     <= '0;
            rcon     <= 8'h01;
            err      <= 1'b0;
            rk_valid <= 1'b0;
            rk_data  <= '0;
            rk_idx   <= '0;
            rk_last  <= 1'b0;
            for (int unsigned j = 0; j < MAX_NK; j++) win[j] <= '0;
            for (int unsigned j = 0; j < 3; j++) rk_buf[j] <= '0;
        end else begin
            err <= (state == IDLE) && start && !legal;

            if (accept) begin
                klen <= key_len;
                idx  <= '0;
                modc <= '0;
                rcon <= 8'h01;
                for (int unsigned j = 0; j < MAX_NK; j++)
                    win[j] <= key_i[KEY_W-1-32*j -: 32];
            end

            if (advance) begin
                for (int unsigned j = 0; j < MAX_NK - 1; j++) win[j] <= win[j+1];
                win[nk_m1] <= new_w;
                if (idx[1:0] != 2'b11) rk_buf[idx[1:0]] <= new_w;
                idx  <= idx + 6'd1;
                modc <= (modc == nk - 4'd1) ? 4'd0 : modc + 4'd1;
                if (expand_phase && modc == 4'd0)
                    rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end

            if (rk_load) begin
                rk_valid <= 1'b1;
                rk_data  <= {rk_buf[0], rk_buf[1], rk_buf[2], new_w};
                rk_idx   <= idx[5:2];
                rk_last  <= (idx[5:2] == nr);
            end else if (rk_pop) begin
                rk_valid <= 1'b0;
            end
        end
    end

endmodule
